onchip_memory_arbiter: RTL and testbench
========================================

// Module: onchip_memory_arbiter
// PURPOSE
//  Shares one single-port 32-bit on-chip RAM (1-cycle read latency, byte enables, clock enable)
//  between two Avalon-MM requesters: M0 = CPU instruction port, M1 = CPU data / DMA port.
//  Arbitrates one transfer per cycle and steers read data back with readdatavalid.
//  Sits between the interconnect masters and the RAM's s1 port.
// PARAMETERS
//  ADDR_W       12   word-address width (4096 words)
//  DATA_W       32   data width; byte-enable width = DATA_W/8
//  RR_MODE      1    1 = round-robin; 0 = fixed priority, M0 wins
//  STARVE_MAX   8    fixed-priority mode only: number of consecutive M1 losses before M1 is forced (1..255)
// PORTS
//  clk                in   1        system clock
//  reset_n            in   1        asynchronous active-low reset
//  freeze             in   1        stall: no grants issued, mem_clken low
//  mN_address         in   ADDR_W   N=0,1 word address
//  mN_byteenable      in   DATA_W/8 byte lanes
//  mN_read            in   1        read request
//  mN_write           in   1        write request (read&write together = protocol error, treated as write)
//  mN_writedata       in   DATA_W   write data
//  mN_lock            in   1        hold grant across back-to-back transfers
//  mN_waitrequest     out  1        high = request not accepted this cycle
//  mN_readdata        out  DATA_W   read data
//  mN_readdatavalid   out  1        one-cycle pulse with readdata
//  mem_address        out  ADDR_W   to RAM
//  mem_byteenable     out  DATA_W/8 to RAM
//  mem_chipselect     out  1        to RAM
//  mem_write          out  1        to RAM
//  mem_writedata      out  DATA_W   to RAM
//  mem_clken          out  1        to RAM, = ~freeze
//  mem_readdata       in   DATA_W   from RAM, valid one cycle after a read is issued
// BEHAVIOUR
//  - Reset: last_grant=M1 (M0 wins first contention), lock_owner=none, starve_cnt=0,
//    rd_pend=0, both readdatavalid=0.
//    Outputs are combinational from state; with no requests they are mem_chipselect=0,
//    mem_write=0 and waitrequest=1 for a requester that is not asking.
//  - Grant, evaluated combinationally each cycle, only while freeze=0:
//    1) A locked owner still requesting wins.
//    2) Only one requester: it wins.
//    3) Contention, RR_MODE=1: the requester that is not last_grant wins.
//    4) Contention, RR_MODE=0: M0 wins unless starve_cnt==STARVE_MAX, then M1 wins.
//  - The winner gets waitrequest=0 and its signals drive mem_*, with mem_chipselect=1.
//    The loser sees waitrequest=1 and must hold its request stable.
//  - Registered updates on every grant:
//    last_grant <= winner.
//    lock_owner <= winner if its lock=1, otherwise cleared.
//    starve_cnt increments when M1 loses under contention, saturating at STARVE_MAX.
//    starve_cnt clears when M1 is granted or stops requesting.
//  - Read return: a granted read sets rd_pend=1 and rd_id=winner.
//    Next cycle mem_readdata goes to both mN_readdata; only m[rd_id]_readdatavalid pulses.
//    rd_pend clears unless a new read is granted. Back-to-back reads give 1 result per cycle.
//  - Writes have no response; a write is complete on the cycle it is accepted.
//  - freeze=1: all waitrequest=1, mem_chipselect=0, mem_clken=0.
//    A pending readdatavalid is delayed until the cycle after freeze falls; RAM output is held by clken.
//    No arbitration state changes during freeze.
//  - Lock is dropped if the owner deasserts its request. Lock never blocks the other
//    requester for more than one idle cycle.
//  - reset_n low mid-transfer: pending read is discarded (no readdatavalid), state returns to reset values.
// STRUCTURE
//  Shared package: grant encoding (GNT_M0, GNT_M1, GNT_NONE) and the default constants
//  ADDR_W/DATA_W/STARVE_MAX.
//  One sub-module is natural: onchip_arb_rr2, the 2-way grant logic (round-robin, fixed
//  priority, starvation counter, lock).
//  Mux and read-return steering stay in the top level.
// TESTING
//  1 Reset, then M0 reads addr 0x010 alone -> m0_waitrequest=0 on the same cycle;
//    m0_readdatavalid=1 next cycle with the stored word; m1_readdatavalid stays 0.
//  2 RR_MODE=1, M0 and M1 both write continuously -> grants alternate M0,M1,M0,...;
//    RAM shows both sets of data with byte enables honoured (be=4'b0101 writes lanes 0 and 2 only).
//  3 RR_MODE=0, STARVE_MAX=3, both request continuously -> M0,M0,M0,M1 repeating.
//  4 M1 asserts lock for a read then a write to 0x100 while M0 requests -> M0 waits 2 cycles;
//    M0 is granted the cycle after M1 drops lock.
//  5 M0 read granted, then freeze=1 for 3 cycles -> no grants and mem_clken=0;
//    m0_readdatavalid appears the cycle after freeze=0 with correct data.
//  6 reset_n asserted the cycle after a read grant -> no readdatavalid;
//    after release the first contention goes to M0.

Source files
------------

// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared constants for the two-master on-chip RAM arbiter.
// Grant codes are one-hot so a zero means no transfer this cycle.
package onchip_memory_arbiter_pkg;

   localparam int ARB_ADDR_W     = 12;
   localparam int ARB_DATA_W     = 32;
   localparam int ARB_STARVE_MAX = 8;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/onchip_arb_rr2.sv
// Two-way grant logic: lock hold, round-robin or fixed priority
// with a starvation counter that eventually forces M1 through.
module onchip_arb_rr2
   import onchip_memory_arbiter_pkg::*;
#(
   parameter int RR_MODE    = 1,
   parameter int STARVE_MAX = ARB_STARVE_MAX
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       freeze_i,
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic       lock0_i,
   input  logic       lock1_i,
   output logic [1:0] gnt_o
);

   localparam logic [7:0] SMAX = 8'(STARVE_MAX);

   logic [1:0] last_q, last_d;
   logic [1:0] lock_q, lock_d;
   logic [7:0] starve_q, starve_d;

   always_comb begin
      gnt_o = GNT_NONE;
      if (!freeze_i) begin
         if (lock_q == GNT_M0 && req0_i) begin
            gnt_o = GNT_M0;
         end else if (lock_q == GNT_M1 && req1_i) begin
            gnt_o = GNT_M1;
         end else if (req0_i && !req1_i) begin
            gnt_o = GNT_M0;
         end else if (req1_i && !req0_i) begin
            gnt_o = GNT_M1;
         end else if (req0_i && req1_i) begin
            if (RR_MODE != 0) begin
               gnt_o = (last_q == GNT_M0) ? GNT_M1 : GNT_M0;
            end else begin
               gnt_o = (starve_q == SMAX) ? GNT_M1 : GNT_M0;
            end
         end
      end
   end

   // Lock ownership is re-decided every unfrozen cycle, so an owner
   // that stops requesting loses it immediately.
   always_comb begin
      last_d   = last_q;
      lock_d   = lock_q;
      starve_d = starve_q;
      if (!freeze_i) begin
         if (gnt_o != GNT_NONE) begin
            last_d = gnt_o;
         end
         lock_d = GNT_NONE;
         if (gnt_o == GNT_M0 && lock0_i) begin
            lock_d = GNT_M0;
         end
         if (gnt_o == GNT_M1 && lock1_i) begin
            lock_d = GNT_M1;
         end
         if (!req1_i || gnt_o == GNT_M1) begin
            starve_d = 8'd0;
         end else if (req0_i && starve_q != SMAX) begin
            starve_d = starve_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q   <= GNT_M1;
         lock_q   <= GNT_NONE;
         starve_q <= 8'd0;
      end else begin
         last_q   <= last_d;
         lock_q   <= lock_d;
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters, one
// transfer per cycle, steering read data back with readdatavalid.
module onchip_memory_arbiter
   import onchip_memory_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ARB_ADDR_W,
   parameter int DATA_W     = ARB_DATA_W,
   parameter int RR_MODE    = 1,
   parameter int STARVE_MAX = ARB_STARVE_MAX
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                freeze,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic                m0_lock,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic                m1_lock,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   logic [1:0] gnt;
   logic       sel1;
   logic       win_read;
   logic       rd_pend_q, rd_pend_d;
   logic [1:0] rd_id_q, rd_id_d;

   onchip_arb_rr2 #(
      .RR_MODE    (RR_MODE),
      .STARVE_MAX (STARVE_MAX)
   ) u_arb (
      .clk      (clk),
      .reset_n  (reset_n),
      .freeze_i (freeze),
      .req0_i   (m0_read | m0_write),
      .req1_i   (m1_read | m1_write),
      .lock0_i  (m0_lock),
      .lock1_i  (m1_lock),
      .gnt_o    (gnt)
   );

   assign sel1 = (gnt == GNT_M1);

   assign m0_waitrequest = (gnt != GNT_M0);
   assign m1_waitrequest = (gnt != GNT_M1);

   assign mem_chipselect = (gnt != GNT_NONE);
   assign mem_clken      = ~freeze;
   assign mem_address    = sel1 ? m1_address    : m0_address;
   assign mem_byteenable = sel1 ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = sel1 ? m1_writedata  : m0_writedata;
   assign mem_write      = mem_chipselect & (sel1 ? m1_write : m0_write);

   // Read+write together is treated as a write, so it gets no response.
   assign win_read = mem_chipselect & ~mem_write;

   always_comb begin
      rd_pend_d = rd_pend_q;
      rd_id_d   = rd_id_q;
      if (!freeze) begin
         rd_pend_d = win_read;
         if (win_read) begin
            rd_id_d = gnt;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend_q <= 1'b0;
         rd_id_q   <= GNT_NONE;
      end else begin
         rd_pend_q <= rd_pend_d;
         rd_id_q   <= rd_id_d;
      end
   end

   // The RAM output is held by clken, so the return simply waits out freeze.
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = rd_pend_q & ~freeze & (rd_id_q == GNT_M0);
   assign m1_readdatavalid = rd_pend_q & ~freeze & (rd_id_q == GNT_M1);

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed bench: a round-robin and a fixed-priority (STARVE_MAX=3)
// arbiter share the same masters, each with its own RAM model.
module tb_onchip_memory_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        freeze = 1'b0;
   logic [11:0] m0_address = '0, m1_address = '0;
   logic [3:0]  m0_be = '0, m1_be = '0;
   logic        m0_read = 0, m0_write = 0, m0_lock = 0;
   logic        m1_read = 0, m1_write = 0, m1_lock = 0;
   logic [31:0] m0_wd = '0, m1_wd = '0;

   logic        a_m0_wait, a_m1_wait, a_m0_rdv, a_m1_rdv;
   logic        a_cs, a_we, a_clken;
   logic [31:0] a_m0_rd, a_m1_rd, a_wd, a_q;
   logic [11:0] a_addr;
   logic [3:0]  a_be;

   logic        b_m0_wait, b_m1_wait, b_m0_rdv, b_m1_rdv;
   logic        b_cs, b_we, b_clken;
   logic [31:0] b_m0_rd, b_m1_rd, b_wd, b_q;
   logic [11:0] b_addr;
   logic [3:0]  b_be;

   logic [31:0] ram_a [0:4095];
   logic [31:0] ram_b [0:4095];

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   onchip_memory_arbiter #(
      .ADDR_W(12), .DATA_W(32), .RR_MODE(1), .STARVE_MAX(8)
   ) u_rr (
      .clk(clk), .reset_n(reset_n), .freeze(freeze),
      .m0_address(m0_address), .m0_byteenable(m0_be),
      .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_wd), .m0_lock(m0_lock),
      .m0_waitrequest(a_m0_wait), .m0_readdata(a_m0_rd),
      .m0_readdatavalid(a_m0_rdv),
      .m1_address(m1_address), .m1_byteenable(m1_be),
      .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_wd), .m1_lock(m1_lock),
      .m1_waitrequest(a_m1_wait), .m1_readdata(a_m1_rd),
      .m1_readdatavalid(a_m1_rdv),
      .mem_address(a_addr), .mem_byteenable(a_be),
      .mem_chipselect(a_cs), .mem_write(a_we),
      .mem_writedata(a_wd), .mem_clken(a_clken),
      .mem_readdata(a_q)
   );

   onchip_memory_arbiter #(
      .ADDR_W(12), .DATA_W(32), .RR_MODE(0), .STARVE_MAX(3)
   ) u_fp (
      .clk(clk), .reset_n(reset_n), .freeze(freeze),
      .m0_address(m0_address), .m0_byteenable(m0_be),
      .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_wd), .m0_lock(m0_lock),
      .m0_waitrequest(b_m0_wait), .m0_readdata(b_m0_rd),
      .m0_readdatavalid(b_m0_rdv),
      .m1_address(m1_address), .m1_byteenable(m1_be),
      .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_wd), .m1_lock(m1_lock),
      .m1_waitrequest(b_m1_wait), .m1_readdata(b_m1_rd),
      .m1_readdatavalid(b_m1_rdv),
      .mem_address(b_addr), .mem_byteenable(b_be),
      .mem_chipselect(b_cs), .mem_write(b_we),
      .mem_writedata(b_wd), .mem_clken(b_clken),
      .mem_readdata(b_q)
   );

   always @(posedge clk) begin
      if (a_clken && a_cs) begin
         if (a_we) begin
            for (int b = 0; b < 4; b++)
               if (a_be[b]) ram_a[a_addr][8*b +: 8] = a_wd[8*b +: 8];
         end else begin
            a_q <= ram_a[a_addr];
         end
      end
   end

   always @(posedge clk) begin
      if (b_clken && b_cs) begin
         if (b_we) begin
            for (int b = 0; b < 4; b++)
               if (b_be[b]) ram_b[b_addr][8*b +: 8] = b_wd[8*b +: 8];
         end else begin
            b_q <= ram_b[b_addr];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic m0_drv(input logic rd, input logic wr,
                         input logic [11:0] ad, input logic [3:0] be,
                         input logic [31:0] wd, input logic lk);
      m0_read = rd; m0_write = wr; m0_address = ad;
      m0_be = be; m0_wd = wd; m0_lock = lk;
   endtask

   task automatic m1_drv(input logic rd, input logic wr,
                         input logic [11:0] ad, input logic [3:0] be,
                         input logic [31:0] wd, input logic lk);
      m1_read = rd; m1_write = wr; m1_address = ad;
      m1_be = be; m1_wd = wd; m1_lock = lk;
   endtask

   task automatic idle();
      m0_drv(0, 0, 12'h000, 4'h0, 32'h0, 0);
      m1_drv(0, 0, 12'h000, 4'h0, 32'h0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      ram_a[12'h010] = 32'hCAFEF00D;
      ram_a[12'h021] = 32'h5A5A5A5A;
      ram_a[12'h100] = 32'h12345678;
      idle();

      // reset state
      tick(); smp();
      check("rst_m0_wait", a_m0_wait, 1);
      check("rst_m1_wait", a_m1_wait, 1);
      check("rst_cs", a_cs, 0);
      check("rst_we", a_we, 0);
      check("rst_rdv0", a_m0_rdv, 0);
      check("rst_rdv1", a_m1_rdv, 0);
      check("rst_clken", a_clken, 1);
      tick(); reset_n = 1'b1;

      // 1: lone M0 read
      tick(); m0_drv(1, 0, 12'h010, 4'hF, 32'h0, 0); smp();
      check("t1_m0_wait", a_m0_wait, 0);
      check("t1_cs", a_cs, 1);
      check("t1_addr", a_addr, 32'h010);
      check("t1_we", a_we, 0);
      tick(); idle(); smp();
      check("t1_rdv0", a_m0_rdv, 1);
      check("t1_data", a_m0_rd, 32'hCAFEF00D);
      check("t1_rdv1", a_m1_rdv, 0);
      tick(); smp();
      check("t1_rdv0_off", a_m0_rdv, 0);

      // 2: round-robin writes, last grant was M0 so M1 goes first
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 0) begin
            m0_drv(0, 1, 12'h020, 4'hF, 32'h11223344, 0);
            m1_drv(0, 1, 12'h021, 4'b0101, 32'hAABBCCDD, 0);
         end
         smp();
         check("t2_m1_wait", a_m1_wait, (k % 2 == 1));
         check("t2_m0_wait", a_m0_wait, (k % 2 == 0));
         check("t2_addr", a_addr, (k % 2 == 0) ? 32'h021 : 32'h020);
      end
      tick(); idle(); smp();
      check("t2_ram_m0", ram_a[12'h020], 32'h11223344);
      check("t2_ram_m1_be", ram_a[12'h021], 32'h5ABB5ADD);

      // 3: fixed priority, M1 forced after three losses
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 0) begin
            m0_drv(0, 1, 12'h030, 4'hF, 32'h1, 0);
            m1_drv(0, 1, 12'h031, 4'hF, 32'h2, 0);
         end
         smp();
         check("t3_fp_m0_wait", b_m0_wait, (k % 4 == 3));
         check("t3_fp_m1_wait", b_m1_wait, (k % 4 != 3));
      end
      tick(); idle(); smp();

      // 4: M1 locked read then write; RR would otherwise pick M0
      tick();
      m0_drv(1, 0, 12'h010, 4'hF, 32'h0, 0);
      m1_drv(1, 0, 12'h100, 4'hF, 32'h0, 1);
      smp();
      check("t4_c0_m1_wait", a_m1_wait, 0);
      check("t4_c0_m0_wait", a_m0_wait, 1);
      tick(); m1_drv(0, 1, 12'h100, 4'hF, 32'h0BADBEEF, 0); smp();
      check("t4_c1_m0_wait", a_m0_wait, 1);
      check("t4_c1_m1_wait", a_m1_wait, 0);
      check("t4_c1_m1_rdv", a_m1_rdv, 1);
      check("t4_c1_m1_data", a_m1_rd, 32'h12345678);
      check("t4_c1_m0_rdv", a_m0_rdv, 0);
      tick(); m1_drv(0, 0, 12'h000, 4'h0, 32'h0, 0); smp();
      check("t4_c2_m0_wait", a_m0_wait, 0);
      tick(); idle(); smp();
      check("t4_c3_m0_rdv", a_m0_rdv, 1);
      check("t4_c3_m0_data", a_m0_rd, 32'hCAFEF00D);
      check("t4_ram", ram_a[12'h100], 32'h0BADBEEF);

      // 5: read then three frozen cycles
      tick(); m0_drv(1, 0, 12'h020, 4'hF, 32'h0, 0); smp();
      check("t5_m0_wait", a_m0_wait, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         if (k == 0) begin
            m0_drv(0, 0, 12'h000, 4'h0, 32'h0, 0);
            m1_drv(1, 0, 12'h021, 4'hF, 32'h0, 0);
            freeze = 1'b1;
         end
         smp();
         check("t5_frz_m1_wait", a_m1_wait, 1);
         check("t5_frz_cs", a_cs, 0);
         check("t5_frz_clken", a_clken, 0);
         check("t5_frz_rdv0", a_m0_rdv, 0);
      end
      tick(); freeze = 1'b0; smp();
      check("t5_rdv0", a_m0_rdv, 1);
      check("t5_data0", a_m0_rd, 32'h11223344);
      check("t5_m1_wait", a_m1_wait, 0);
      tick(); idle(); smp();
      check("t5_rdv1", a_m1_rdv, 1);
      check("t5_data1", a_m1_rd, 32'h5ABB5ADD);
      check("t5_rdv0_off", a_m0_rdv, 0);

      // 6: reset right after a read grant
      tick(); m0_drv(1, 0, 12'h010, 4'hF, 32'h0, 0); smp();
      check("t6_m0_wait", a_m0_wait, 0);
      tick(); idle(); reset_n = 1'b0; smp();
      check("t6_rst_rdv0", a_m0_rdv, 0);
      check("t6_rst_rdv1", a_m1_rdv, 0);
      tick(); reset_n = 1'b1; smp();
      check("t6_rel_rdv0", a_m0_rdv, 0);
      tick();
      m0_drv(1, 0, 12'h010, 4'hF, 32'h0, 0);
      m1_drv(1, 0, 12'h021, 4'hF, 32'h0, 0);
      smp();
      check("t6_m0_wait", a_m0_wait, 0);
      check("t6_m1_wait", a_m1_wait, 1);
      tick(); idle(); smp();
      check("t6_rdv0", a_m0_rdv, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
